// File: rtl/sensor_stream_capture.sv
// Packs per-lane DDR sample pairs into 256-bit capture-FIFO words (sample 0 in the top 64 bits).
// Define CAPTURE_INPUT_REG_EN to register sample_en/d_rise/d_fall/stop once before packing.
module sensor_stream_capture #(
   parameter int LANES = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [31:0]      num_words,
   input  logic             sample_en,
   input  logic [LANES-1:0] d_rise,
   input  logic [LANES-1:0] d_fall,
   input  logic             fifo_almost_full,
   output logic [255:0]     fifo_din,
   output logic             fifo_wr_en,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [31:0]      words_written,
   output logic [15:0]      drop_count
);

   typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

   state_t             state;
   logic               vld_p0;
   logic               stop_p0;
   logic [LANES-1:0]   rise_p0;
   logic [LANES-1:0]   fall_p0;
   logic [1:0]         beat_idx;
   logic [1:0]         beat_next;
   logic [255:0]       word_acc;
   logic [255:0]       word_next;
   logic [255:0]       emit_word;
   logic [63:0]        smp;
   logic [31:0]        num_words_lat;
   logic [31:0]        completed;
   logic               word_done;
   logic               last_word;
   logic               emit;

   function automatic logic [63:0] pack_sample(input logic [LANES-1:0] r, input logic [LANES-1:0] f);
      logic [63:0] s;
      s = '0;
      s[LANES-1:0]     = r;
      s[32+LANES-1:32] = f;
      return s;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

`ifdef CAPTURE_INPUT_REG_EN
   // Input stage p0: stop travels with the samples so in-flight data is still captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         stop_p0 <= 1'b0;
      end else begin
         vld_p0  <= sample_en;
         stop_p0 <= stop;
      end
   end

   always_ff @(posedge clk) begin
      rise_p0 <= d_rise;
      fall_p0 <= d_fall;
   end
`else
   assign vld_p0  = sample_en;
   assign stop_p0 = stop;
   assign rise_p0 = d_rise;
   assign fall_p0 = d_fall;
`endif

   assign smp = pack_sample(rise_p0, fall_p0);

   always_comb begin
      word_next = word_acc;
      if (vld_p0) begin
         case (beat_idx)
            2'd0:    word_next[255:192] = smp;
            2'd1:    word_next[191:128] = smp;
            2'd2:    word_next[127:64]  = smp;
            default: word_next[63:0]    = smp;
         endcase
      end
   end

   assign beat_next = beat_idx + {1'b0, vld_p0};
   assign word_done = (state == CAPTURE) && vld_p0 && (beat_idx == 2'd3);
   assign last_word = word_done && (num_words_lat != 32'd0) && (completed + 32'd1 == num_words_lat);
   assign emit      = word_done || (state == FLUSH);
   assign emit_word = (state == FLUSH) ? word_acc : word_next;

   // Output stage: FIFO write/drop, counters and FSM all register on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         beat_idx      <= 2'd0;
         word_acc      <= '0;
         num_words_lat <= 32'd0;
         completed     <= 32'd0;
         fifo_din      <= '0;
         fifo_wr_en    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         words_written <= 32'd0;
         drop_count    <= 16'd0;
      end else begin
         fifo_wr_en <= 1'b0;
         done       <= 1'b0;
         if (emit) begin
            if (!fifo_almost_full) begin
               fifo_din      <= emit_word;
               fifo_wr_en    <= 1'b1;
               words_written <= words_written + 32'd1;
            end else begin
               drop_count <= sat_inc16(drop_count);
               overflow   <= 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= CAPTURE;
                  busy          <= 1'b1;
                  beat_idx      <= 2'd0;
                  word_acc      <= '0;
                  completed     <= 32'd0;
                  words_written <= 32'd0;
                  drop_count    <= 16'd0;
                  overflow      <= 1'b0;
                  num_words_lat <= num_words;
               end
            end
            CAPTURE: begin
               beat_idx <= beat_next;
               word_acc <= word_done ? '0 : word_next;
               if (word_done) completed <= completed + 32'd1;
               // Terminal count wins over stop; a stop on a word boundary needs no flush.
               if (last_word || (stop_p0 && beat_next == 2'd0)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (stop_p0) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
               beat_idx <= 2'd0;
               word_acc <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_stream_capture.sv
// Bench for sensor_stream_capture: sample-queue reference model checked every cycle plus scenario checks.
module tb_sensor_stream_capture;

   localparam int LANES = 20;

   logic             clk;
   logic             reset;
   logic             start;
   logic             stop;
   logic [31:0]      num_words;
   logic             sample_en;
   logic [LANES-1:0] d_rise;
   logic [LANES-1:0] d_fall;
   logic             fifo_almost_full;
   logic [255:0]     fifo_din;
   logic             fifo_wr_en;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [31:0]      words_written;
   logic [15:0]      drop_count;

   sensor_stream_capture #(.LANES(LANES)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .num_words(num_words),
      .sample_en(sample_en), .d_rise(d_rise), .d_fall(d_fall),
      .fifo_almost_full(fifo_almost_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .busy(busy), .done(done), .overflow(overflow), .words_written(words_written),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle_no = 0;
   int cyc_bad = 0;
   string first_msg = "";

   logic         m_active = 1'b0;
   logic         m_flush = 1'b0;
   logic [63:0]  m_samples[$];
   logic [31:0]  m_nw = 32'd0;
   logic [31:0]  m_count = 32'd0;
   logic [31:0]  m_ww = 32'd0;
   logic [15:0]  m_drop = 16'd0;
   logic         m_ovf = 1'b0;

   logic [255:0] dut_words[$];
   int           dut_cyc[$];

   function automatic logic [63:0] samp(input logic [LANES-1:0] r, input logic [LANES-1:0] f);
      return (64'(f) << 32) | 64'(r);
   endfunction

   task automatic model_emit(input logic [255:0] w, output logic wr, output logic [255:0] din);
      wr = 1'b0;
      din = '0;
      if (!fifo_almost_full) begin
         wr = 1'b1;
         din = w;
         m_ww++;
      end else begin
         if (m_drop != 16'hFFFF) m_drop++;
         m_ovf = 1'b1;
      end
   endtask

   task automatic quiet();
      start = 1'b0;
      stop = 1'b0;
      sample_en = 1'b0;
      fifo_almost_full = 1'b0;
   endtask

   task automatic clear_trace();
      cyc_bad = 0;
      first_msg = "";
      dut_words.delete();
      dut_cyc.delete();
   endtask

   // One clock: advance the reference model with the applied inputs, then compare all outputs.
   task automatic tick();
      logic         exp_wr, exp_done, ended;
      logic [255:0] exp_din, w;
      @(posedge clk);
      cycle_no++;
      exp_wr = 1'b0;
      exp_done = 1'b0;
      exp_din = '0;
      ended = 1'b0;
      if (reset) begin
         m_active = 1'b0; m_flush = 1'b0; m_samples.delete();
         m_ww = 0; m_drop = 0; m_ovf = 1'b0; m_count = 0;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1'b1; m_samples.delete();
            m_ww = 0; m_drop = 0; m_ovf = 1'b0; m_count = 0; m_nw = num_words;
         end
      end else if (m_flush) begin
         w = '0;
         foreach (m_samples[i]) w[255-64*i -: 64] = m_samples[i];
         model_emit(w, exp_wr, exp_din);
         m_samples.delete();
         m_flush = 1'b0;
         m_active = 1'b0;
         exp_done = 1'b1;
      end else begin
         if (sample_en) m_samples.push_back(samp(d_rise, d_fall));
         if (m_samples.size() == 4) begin
            w = {m_samples[0], m_samples[1], m_samples[2], m_samples[3]};
            model_emit(w, exp_wr, exp_din);
            m_samples.delete();
            m_count++;
            if (m_nw != 0 && m_count == m_nw) ended = 1'b1;
         end
         if (!ended && stop) begin
            if (m_samples.size() != 0) m_flush = 1'b1;
            else ended = 1'b1;
         end
         if (ended) begin
            m_active = 1'b0;
            exp_done = 1'b1;
         end
      end
      #1;
      if (fifo_wr_en !== exp_wr || (exp_wr && fifo_din !== exp_din) || done !== exp_done ||
          busy !== m_active || overflow !== m_ovf || words_written !== m_ww || drop_count !== m_drop) begin
         if (cyc_bad == 0)
            first_msg = $sformatf("cycle %0d wr=%b/%b din_ok=%b done=%b/%b busy=%b/%b ovf=%b/%b ww=%0d/%0d drop=%0d/%0d",
               cycle_no, fifo_wr_en, exp_wr, (fifo_din === exp_din), done, exp_done, busy, m_active,
               overflow, m_ovf, words_written, m_ww, drop_count, m_drop);
         cyc_bad++;
      end
      if (fifo_wr_en === 1'b1) begin
         dut_words.push_back(fifo_din);
         dut_cyc.push_back(cycle_no);
      end
   endtask

   task automatic test_reset();
      checks++; if (fifo_din !== 256'd0) begin errors++; $display("FAIL reset_din: got %h required 0", fifo_din); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", fifo_wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      checks++; if (words_written !== 32'd0) begin errors++; $display("FAIL reset_words: got %0d required 0", words_written); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d required 0", drop_count); end
   endtask

   task automatic test_full_words();
      clear_trace();
      num_words = 32'd2; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sample_en = 1'b1; d_rise = LANES'(k); d_fall = ~LANES'(k); tick();
      end
      sample_en = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_done: done=%b busy=%b required 1/0", done, busy); end
      checks++;
      if (dut_words.size() != 2) begin
         errors++; $display("FAIL full_count: got %0d writes required 2", dut_words.size());
      end else begin
         checks++; if (dut_cyc[1] - dut_cyc[0] != 4) begin errors++; $display("FAIL full_spacing: got %0d required 4", dut_cyc[1] - dut_cyc[0]); end
         checks++; if (dut_words[0][255:192] !== 64'h000F_FFFF_0000_0000) begin errors++; $display("FAIL full_slot0: got %h required 000fffff00000000", dut_words[0][255:192]); end
      end
      checks++; if (words_written !== 32'd2) begin errors++; $display("FAIL full_words_written: got %0d required 2", words_written); end
      tick();
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL full_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_flush();
      logic [63:0] s[6];
      clear_trace();
      num_words = 32'd0; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sample_en = 1'b1; d_rise = LANES'($urandom); d_fall = LANES'($urandom);
         s[k] = samp(d_rise, d_fall); tick();
      end
      sample_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL flush_enter: busy=%b wr=%b required 1/0", busy, fifo_wr_en); end
      tick();
      checks++; if (done !== 1'b1 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL flush_write: done=%b wr=%b required 1/1", done, fifo_wr_en); end
      checks++;
      if (dut_words.size() != 2) begin
         errors++; $display("FAIL flush_count: got %0d writes required 2", dut_words.size());
      end else begin
         checks++; if (dut_words[1] !== {s[4], s[5], 128'd0}) begin errors++; $display("FAIL flush_word: got %h required %h", dut_words[1], {s[4], s[5], 128'd0}); end
      end
      checks++; if (words_written !== 32'd2) begin errors++; $display("FAIL flush_words_written: got %0d required 2", words_written); end
      tick();
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL flush_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_backpressure();
      clear_trace();
      num_words = 32'd3; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         sample_en = 1'b1; d_rise = LANES'($urandom); d_fall = LANES'($urandom);
         fifo_almost_full = (k >= 4 && k < 8); tick();
      end
      sample_en = 1'b0; fifo_almost_full = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b required 1", done); end
      checks++; if (dut_words.size() != 2) begin errors++; $display("FAIL bp_writes: got %0d required 2", dut_words.size()); end
      checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL bp_drops: got %0d required 1", drop_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b required 1", overflow); end
      num_words = 32'd1; start = 1'b1; tick(); start = 1'b0;
      checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL bp_restart_clear: ovf=%b drops=%0d required 0/0", overflow, drop_count); end
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_stop_empty: done=%b busy=%b required 1/0", done, busy); end
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL bp_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_gapped();
      logic [63:0] s[4];
      int n, t4;
      clear_trace();
      n = 0; t4 = -1;
      num_words = 32'd1; start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         sample_en = (c % 3 == 0) && (n < 4);
         d_rise = LANES'($urandom); d_fall = LANES'($urandom);
         if (sample_en) begin s[n] = samp(d_rise, d_fall); n++; end
         tick();
         if (sample_en && n == 4) t4 = cycle_no;
      end
      sample_en = 1'b0;
      checks++;
      if (dut_words.size() != 1) begin
         errors++; $display("FAIL gap_count: got %0d writes required 1", dut_words.size());
      end else begin
         checks++; if (dut_cyc[0] != t4) begin errors++; $display("FAIL gap_latency: write at cycle %0d required %0d", dut_cyc[0], t4); end
         checks++; if (dut_words[0] !== {s[0], s[1], s[2], s[3]}) begin errors++; $display("FAIL gap_packing: got %h required %h", dut_words[0], {s[0], s[1], s[2], s[3]}); end
      end
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL gap_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] s[4];
      clear_trace();
      num_words = 32'd4; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sample_en = 1'b1; d_rise = LANES'($urandom); d_fall = LANES'($urandom); tick();
      end
      sample_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
          words_written !== 32'd0 || drop_count !== 16'd0 || fifo_din !== 256'd0) begin
         errors++; $display("FAIL rstmid_outputs: wr=%b busy=%b done=%b ovf=%b ww=%0d drops=%0d din_zero=%b required all 0",
            fifo_wr_en, busy, done, overflow, words_written, drop_count, (fifo_din === 256'd0));
      end
      num_words = 32'd1; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample_en = 1'b1; d_rise = LANES'($urandom); d_fall = LANES'($urandom);
         s[k] = samp(d_rise, d_fall); tick();
      end
      sample_en = 1'b0;
      checks++;
      if (dut_words.size() != 1) begin
         errors++; $display("FAIL rstmid_count: got %0d writes required 1", dut_words.size());
      end else begin
         checks++; if (dut_words[0] !== {s[0], s[1], s[2], s[3]}) begin errors++; $display("FAIL rstmid_packing: got %h required %h", dut_words[0], {s[0], s[1], s[2], s[3]}); end
      end
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL rstmid_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_stop_fourth();
      clear_trace();
      num_words = 32'd0; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample_en = 1'b1; d_rise = LANES'($urandom); d_fall = LANES'($urandom);
         stop = (k == 3); tick();
      end
      sample_en = 1'b0; stop = 1'b0;
      checks++; if (fifo_wr_en !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL stop4_write_done: wr=%b done=%b required 1/1", fifo_wr_en, done); end
      tick();
      checks++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop4_no_flush: wr=%b busy=%b required 0/0", fifo_wr_en, busy); end
      checks++; if (cyc_bad != 0) begin errors++; $display("FAIL stop4_trace: %0d bad cycles required 0; %s", cyc_bad, first_msg); end
   endtask

   task automatic test_random();
      int stop_at;
      for (int run = 0; run < 12; run++) begin
         clear_trace();
         num_words = 32'($urandom_range(0, 3));
         stop_at = $urandom_range(3, 30);
         start = 1'b1; tick(); start = 1'b0;
         for (int c = 0; c < 80 && m_active; c++) begin
            sample_en = ($urandom % 3) != 0;
            d_rise = LANES'($urandom); d_fall = LANES'($urandom);
            fifo_almost_full = ($urandom % 4) == 0;
            start = ($urandom % 16) == 0;
            stop = (c == stop_at) || (c >= 60);
            tick();
         end
         quiet();
         checks++; if (m_active) begin errors++; $display("FAIL rand_timeout: run %0d still busy=%b after budget, required finished", run, busy); end
         repeat (2) begin
            stop = ($urandom % 2) == 0; tick(); stop = 1'b0;
         end
         checks++; if (cyc_bad != 0) begin errors++; $display("FAIL rand_trace: run %0d %0d bad cycles required 0; %s", run, cyc_bad, first_msg); end
      end
   endtask

   initial begin
      reset = 1'b1; num_words = 32'd0; d_rise = '0; d_fall = '0;
      quiet();
      repeat (3) tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_full_words();
      test_flush();
      test_backpressure();
      test_gapped();
      test_reset_mid();
      test_stop_fourth();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_stream_capture.md
# sensor_stream_capture

Receive-side counterpart of the pattern-to-sensor path: captures the per-lane DDR sample pairs returned by the sensor array, after the external IDDR primitives, and packs four 64-bit samples into 256-bit words. It writes those words into the 256-bit-wide capture FIFO that software drains. The 64-bit sample layout and the 256-bit packing order mirror the transmit FIFO, so a looped-back pattern reproduces the original MSTREAM32 words bit for bit.

## Interface

Parameters:
- LANES, 20, number of sensor lanes; legal range 1..32.

Ports:
- clk  in  1  capture clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; arms a capture.
- stop  in  1  single-cycle pulse; ends a capture early.
- num_words  in  32  number of 256-bit words per capture; 0 means run until stop.
- sample_en  in  1  qualifies d_rise/d_fall in the current cycle.
- d_rise  in  LANES  rising-edge sample per lane.
- d_fall  in  LANES  falling-edge sample per lane.
- fifo_almost_full  in  1  backpressure from the capture FIFO.
- fifo_din  out  256  packed word.
- fifo_wr_en  out  1  write strobe, one cycle per word.
- busy  out  1  high while in CAPTURE or FLUSH.
- done  out  1  one-cycle pulse when a capture ends.
- overflow  out  1  sticky; set when any word is dropped; cleared by start or reset.
- words_written  out  32  words actually written to the FIFO in the current or last capture.
- drop_count  out  16  words dropped; saturates at 16'hFFFF.

## Operation

- Sample format: bits [LANES-1:0] = d_rise and bits [32+LANES-1:32] = d_fall. All other bits are 0.
- Packing: beat counter beat_idx runs 0..3. Sample 0 occupies fifo_din[255:192], sample 1 [191:128], sample 2 [127:64] and sample 3 [63:0]. This is the read order of the 256-to-64 transmit FIFO.
- States: IDLE, CAPTURE, FLUSH.
- IDLE:
  - start moves to CAPTURE.
  - On that transition: clear beat_idx, words_written, drop_count and overflow, and latch num_words.
  - sample_en is ignored.
- CAPTURE:
  - Each cycle with sample_en high stores the sample at beat_idx and increments beat_idx.
  - At beat_idx == 3 the word is complete and beat_idx wraps to 0.
  - If fifo_almost_full is low at completion: write the word and increment words_written.
  - If fifo_almost_full is high at completion: drop the word, increment drop_count (saturating) and set overflow.
  - Completed words, written plus dropped, count toward num_words. When the count reaches a nonzero num_words: pulse done and go to IDLE.
- stop in CAPTURE:
  - The sample present in the same cycle, if any, is taken first.
  - If a partial word remains (beat_idx != 0 after that sample), go to FLUSH. Otherwise pulse done and go to IDLE.
- FLUSH (one cycle): write the partial word with untaken slots zero, subject to the same almost_full drop rule. Then pulse done and go to IDLE.
- start while busy is ignored. stop in IDLE is ignored.
- Word completion on the same cycle as the terminal count and stop: treat as terminal count; no FLUSH.
- reset mid-capture: discard the partial word and go to IDLE with all outputs at reset values.

## Timing

- Reset values: fifo_din = 0, fifo_wr_en = 0, busy = 0, done = 0, overflow = 0, words_written = 0, drop_count = 0.
- Latency from the fourth sample's sample_en cycle to fifo_wr_en is 1 cycle; fifo_din is valid in the same cycle as fifo_wr_en.
- fifo_almost_full is sampled in the completing cycle.
- done is asserted in the same cycle as the final fifo_wr_en, or in the cycle after the final completion if that word was dropped.
- busy rises the cycle after start and falls in the same cycle that done pulses.
- Back-to-back words are supported: one fifo_wr_en every 4 cycles at full sample rate.
- FLUSH adds 1 cycle after stop.

## Configuration

- CAPTURE_INPUT_REG_EN defined: adds one register stage on sample_en, d_rise and d_fall before packing. This eases timing from the IDDR outputs. Latency from the fourth sample to fifo_wr_en becomes 2 cycles. stop is delayed equally so that in-flight samples are captured.
- CAPTURE_INPUT_REG_EN undefined: inputs are used directly, with 1-cycle latency.

## Test plan

- start with num_words = 2, then 8 consecutive samples with d_rise = k and d_fall = ~k. Required response: 2 writes, 4 cycles apart; first word [255:192] = {12'h0, 20'hFFFFF, 12'h0, 20'h00000}. Then done, words_written = 2 and busy = 0.
- num_words = 0, 6 samples, then stop. Required response: 1 full write, then a FLUSH write with [127:0] = 0. done fires in the FLUSH cycle and words_written = 2.
- fifo_almost_full held high during the second word of num_words = 3. Required response: 2 writes, drop_count = 1, overflow = 1 and done after the third word. The next start clears overflow.
- Gapped sample_en (1 cycle on, 2 off) with num_words = 1. Required response: a single write, 1 cycle after the fourth qualified sample, with the correct packing order.
- reset asserted after 2 samples of a capture. Required response: the next cycle shows all outputs at reset values and no write. A subsequent capture packs from slot 0.
- stop and the fourth sample of a word in the same cycle. Required response: the word is written with no FLUSH, and done is asserted in that write cycle.
